// File: rtl/one_hot_calculator_pkg.sv
// Shared constants and types for the one-hot shift-and-add multiplier.
// State-bit indices, the one-hot state vector type and datapath widths.
package one_hot_calculator_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;
   localparam int CNT_W  = 3;
   localparam int N_ST   = 6;

   localparam int S_IDLE  = 0;
   localparam int S_LOAD  = 1;
   localparam int S_TEST  = 2;
   localparam int S_ADD   = 3;
   localparam int S_SHIFT = 4;
   localparam int S_DONE  = 5;

   typedef logic [N_ST-1:0] state_vec_t;

   localparam state_vec_t ST_IDLE = 6'b000001;

   function automatic logic is_one_hot(input state_vec_t v);
      return (v != '0) && ((v & (v - 6'd1)) == '0);
   endfunction

endpackage

// File: rtl/one_hot_calculator_datapath.sv
// Multiplier datapath: multiplicand M, multiplier Q, partial product P,
// bit counter CNT and the published result register, driven by FSM strobes.
module one_hot_calculator_datapath
   import one_hot_calculator_pkg::*;
#(
   parameter logic [OP_W-1:0] A_VAL = 4'd13,
   parameter logic [OP_W-1:0] B_VAL = 4'd11
) (
   input  logic              clk_i,
   input  logic              clear_b_i,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              add_i,
   input  logic              shift_i,
   output logic              q0_o,
   output logic              cnt_last_o,
   output logic [PROD_W-1:0] led_o
);

   logic [PROD_W-1:0] m_q, m_d;
   logic [OP_W-1:0]   q_q, q_d;
   logic [PROD_W-1:0] p_q, p_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] led_q, led_d;

   assign q0_o       = q_q[0];
   assign cnt_last_o = (cnt_q == 3'd1);
   assign led_o      = led_q;

   always_comb begin
      m_d   = m_q;
      q_d   = q_q;
      p_d   = p_q;
      cnt_d = cnt_q;
      led_d = led_q;
      if (flush_i) begin
         m_d   = '0;
         q_d   = '0;
         p_d   = '0;
         cnt_d = '0;
      end else begin
         if (load_i) begin
            m_d   = {4'b0000, A_VAL};
            q_d   = B_VAL;
            p_d   = '0;
            cnt_d = 3'd4;
         end
         if (add_i) begin
            p_d = p_q + m_q;
         end
         // P is final by the last shift, so it is published on that same edge
         if (shift_i) begin
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_last_o) begin
               led_d = p_q;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clear_b_i) begin
         m_q   <= '0;
         q_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
         led_q <= '0;
      end else begin
         m_q   <= m_d;
         q_q   <= q_d;
         p_q   <= p_d;
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

endmodule

// File: rtl/one_hot_calculator.sv
// One-hot FSM sequencing a 4x4 shift-and-add multiply; result on LED_OUT.
// Define ONEHOT_RECOVERY_EN to build the illegal-state recovery check.
//
//   state | meaning
//   IDLE  | waiting for Start
//   LOAD  | load operands, clear product, CNT=4
//   TEST  | inspect Q[0]
//   ADD   | P += M
//   SHIFT | M<<1, Q>>1, CNT-1; publish product on last bit
//   DONE  | one-cycle completion, back to IDLE
module one_hot_calculator
   import one_hot_calculator_pkg::*;
#(
   parameter logic [OP_W-1:0] A_VAL = 4'd13,
   parameter logic [OP_W-1:0] B_VAL = 4'd11
) (
   input  logic              CLK_50,
   input  logic              Clear,
   input  logic              Start,
   output logic [PROD_W-1:0] LED_OUT
);

   state_vec_t state_q, state_d;
   logic       flush;
   logic       q0;
   logic       cnt_last;

   always_ff @(posedge CLK_50) begin
      if (!Clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = '0;
      flush   = 1'b0;
      state_d[S_IDLE]  = (state_q[S_IDLE] & ~Start) | state_q[S_DONE];
      state_d[S_LOAD]  = state_q[S_IDLE] & Start;
      state_d[S_TEST]  = state_q[S_LOAD] | (state_q[S_SHIFT] & ~cnt_last);
      state_d[S_ADD]   = state_q[S_TEST] & q0;
      state_d[S_SHIFT] = state_q[S_ADD] | (state_q[S_TEST] & ~q0);
      state_d[S_DONE]  = state_q[S_SHIFT] & cnt_last;
`ifdef ONEHOT_RECOVERY_EN
      if (!is_one_hot(state_q)) begin
         state_d = ST_IDLE;
         flush   = 1'b1;
      end
`endif
   end

   one_hot_calculator_datapath #(
      .A_VAL (A_VAL),
      .B_VAL (B_VAL)
   ) u_datapath (
      .clk_i      (CLK_50),
      .clear_b_i  (Clear),
      .flush_i    (flush),
      .load_i     (state_q[S_LOAD]),
      .add_i      (state_q[S_ADD]),
      .shift_i    (state_q[S_SHIFT]),
      .q0_o       (q0),
      .cnt_last_o (cnt_last),
      .led_o      (LED_OUT)
   );

endmodule

// File: tb/tb_one_hot_calculator.sv
// Scoreboard bench for one_hot_calculator: three instances (13x11, 15x15, 9x0)
// with expected LED_OUT values queued per edge and checked by a monitor.
module tb_one_hot_calculator;

   logic       clk = 1'b0;
   logic       clear_b;
   logic       st0, st1, st2;
   logic [7:0] led0, led1, led2;

   always #10 clk = ~clk;

   one_hot_calculator dut0 (
      .CLK_50 (clk), .Clear (clear_b), .Start (st0), .LED_OUT (led0)
   );
   one_hot_calculator #(.A_VAL(4'd15), .B_VAL(4'd15)) dut1 (
      .CLK_50 (clk), .Clear (clear_b), .Start (st1), .LED_OUT (led1)
   );
   one_hot_calculator #(.A_VAL(4'd9), .B_VAL(4'd0)) dut2 (
      .CLK_50 (clk), .Clear (clear_b), .Start (st2), .LED_OUT (led2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   exp_t  sbq[3][$];
   int    n_cmp = 0;
   int    n_bad = 0;
   string dname[3] = '{"a13b11", "a15b15", "a9b0"};

   function automatic logic [7:0] led_of(input int k);
      case (k)
         0:       return led0;
         1:       return led1;
         default: return led2;
      endcase
   endfunction

   task automatic expect_led(input int k, input int c, input logic [7:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      sbq[k].push_back(e);
   endtask

   task automatic expect_span(input int k, input int c0, input int c1, input logic [7:0] v);
      for (int c = c0; c <= c1; c++) expect_led(k, c, v);
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: LED_OUT is sampled on the falling edge after edge number cyc
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         while (sbq[k].size() > 0 && sbq[k][0].cyc <= cyc) begin
            e = sbq[k].pop_front();
            n_cmp++;
            if (led_of(k) !== e.val) begin
               n_bad++;
               $display("FAIL led_%s edge %0d: LED_OUT=%h expected %h",
                        dname[k], cyc, led_of(k), e.val);
            end
         end
      end
   end

   int s, s2, guard;

   initial begin
      // Clear held low for two edges with Start asserted on every instance
      clear_b = 1'b0;
      st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
      for (int k = 0; k < 3; k++) expect_span(k, 1, 2, 8'h00);
      to_cyc(2);
      clear_b = 1'b1;
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      for (int k = 0; k < 3; k++) expect_span(k, 3, 6, 8'h00);
      to_cyc(6);

      n_cmp++;
      if (led0 !== 8'h00) begin
         n_bad++;
         $display("FAIL idle_a13b11: LED_OUT=%h expected 00", led0);
      end
      n_cmp++;
      if (led1 !== 8'h00) begin
         n_bad++;
         $display("FAIL idle_a15b15: LED_OUT=%h expected 00", led1);
      end
      n_cmp++;
      if (led2 !== 8'h00) begin
         n_bad++;
         $display("FAIL idle_a9b0: LED_OUT=%h expected 00", led2);
      end

      // One-cycle Start on all three; a stray Start on dut0 at run edge 5
      s = cyc + 1;
      st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
      expect_span(0, s + 1, s + 11, 8'h00);
      expect_span(0, s + 12, s + 20, 8'h8F);
      expect_span(1, s + 1, s + 12, 8'h00);
      expect_span(1, s + 13, s + 20, 8'hE1);
      expect_span(2, s + 1, s + 20, 8'h00);
      @(negedge clk);
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      to_cyc(s + 4);
      st0 = 1'b1;
      @(negedge clk);
      st0 = 1'b0;
      to_cyc(s + 20);

      n_cmp++;
      if (led0 !== 8'h8F) begin
         n_bad++;
         $display("FAIL run1_a13b11: LED_OUT=%h expected 8f", led0);
      end
      n_cmp++;
      if (led1 !== 8'hE1) begin
         n_bad++;
         $display("FAIL run1_a15b15: LED_OUT=%h expected e1", led1);
      end
      n_cmp++;
      if (led2 !== 8'h00) begin
         n_bad++;
         $display("FAIL run1_a9b0: LED_OUT=%h expected 00", led2);
      end

      // Clear at run edge 6 aborts; previous results held until then
      s = cyc + 1;
      st0 = 1'b1;
      expect_span(0, s + 1, s + 5, 8'h8F);
      expect_span(1, s + 1, s + 5, 8'hE1);
      expect_span(2, s + 1, s + 5, 8'h00);
      @(negedge clk);
      st0 = 1'b0;
      to_cyc(s + 5);
      clear_b = 1'b0;
      for (int k = 0; k < 3; k++) expect_span(k, s + 6, s + 10, 8'h00);
      @(negedge clk);
      clear_b = 1'b1;
      to_cyc(s + 10);

      // Fresh runs after the abort
      s2 = cyc + 1;
      st0 = 1'b1; st1 = 1'b1;
      expect_span(0, s2 + 1, s2 + 11, 8'h00);
      expect_span(0, s2 + 12, s2 + 14, 8'h8F);
      expect_span(1, s2 + 1, s2 + 12, 8'h00);
      expect_span(1, s2 + 13, s2 + 14, 8'hE1);
      @(negedge clk);
      st0 = 1'b0; st1 = 1'b0;
      to_cyc(s2 + 14);

      n_cmp++;
      if (led0 !== 8'h8F) begin
         n_bad++;
         $display("FAIL rerun_a13b11: LED_OUT=%h expected 8f", led0);
      end
      n_cmp++;
      if (led1 !== 8'hE1) begin
         n_bad++;
         $display("FAIL rerun_a15b15: LED_OUT=%h expected e1", led1);
      end

`ifdef ONEHOT_RECOVERY_EN
      // Illegal two-hot state must fall back to IDLE without touching LED_OUT
      s = cyc;
      force dut0.state_q = 6'b000011;
      expect_span(0, s + 1, s + 3, 8'h8F);
      @(negedge clk);
      release dut0.state_q;
      to_cyc(s + 2);
      s2 = cyc + 1;
      st0 = 1'b1;
      expect_span(0, s2 + 1, s2 + 14, 8'h8F);
      @(negedge clk);
      st0 = 1'b0;
      to_cyc(s2 + 14);
`endif

      guard = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 3; k++) begin
         while (sbq[k].size() > 0) begin
            exp_t e;
            e = sbq[k].pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s edge %0d: never checked, expected %h", dname[k], e.cyc, e.val);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/one_hot_calculator.md
ONE_HOT_CALCULATOR -- requirements
Module: one_hot_calculator

Interface
REQ-001 Parameter A_VAL, default 4'd13, multiplicand operand (unsigned, 4 bits).
REQ-002 Parameter B_VAL, default 4'd11, multiplier operand (unsigned, 4 bits).
REQ-003 CLK_50  input  1  sole clock, 50 MHz; all state changes on its rising edge.
REQ-004 Clear  input  1  reset, synchronous, active-low: sampled only on the rising edge of CLK_50.
REQ-005 Start  input  1  active-high request to begin one multiplication, sampled on the rising edge of CLK_50.
REQ-006 LED_OUT  output  8  registered product A_VAL*B_VAL from the last completed run.

Function
REQ-007 The controller SHALL be a one-hot FSM with six flops: IDLE, LOAD, TEST, ADD, SHIFT, DONE; exactly one bit is set at all times.
REQ-008 IDLE: Start=1 -> LOAD; Start=0 -> stay IDLE.
REQ-009 LOAD (1 cycle): M <= {4'b0,A_VAL} (8 bits), Q <= B_VAL (4 bits), P <= 8'h00, CNT <= 3'd4; -> TEST.
REQ-010 TEST (1 cycle): Q[0]=1 -> ADD; Q[0]=0 -> SHIFT.
REQ-011 ADD (1 cycle): P <= P + M, modulo 2^8 (never overflows for 4-bit operands); -> SHIFT.
REQ-012 SHIFT (1 cycle): M <= M<<1, Q <= Q>>1, CNT <= CNT-1; CNT=1 -> DONE and LED_OUT <= P on the same edge; otherwise -> TEST.
REQ-013 DONE (1 cycle): -> IDLE unconditionally.
REQ-014 Latency: LED_OUT holds the new product 1 + sum over 4 bits of (3 if bit=1 else 2) rising edges after the edge that sampled Start in IDLE (9 min, 13 max; 12 for defaults).
REQ-015 LED_OUT SHALL hold its previous value during a run and update only at REQ-012 completion.
REQ-016 Start while not in IDLE SHALL be ignored (no restart, no queuing); Start held high re-triggers from IDLE after DONE.

Reset
REQ-017 Clear=0 at a rising edge SHALL force state IDLE, M=Q=P=0, CNT=0, LED_OUT=8'h00, overriding every other input including Start.
REQ-018 Clear=0 mid-run SHALL abort the run; LED_OUT reads 8'h00, no partial result is ever published.

Configuration
REQ-019 With ONEHOT_RECOVERY_EN defined, a state vector that is not exactly one-hot SHALL on the next edge force IDLE and clear M, Q, P, CNT (LED_OUT untouched).
REQ-020 Without ONEHOT_RECOVERY_EN, no legality check is built; behaviour from an illegal state is unspecified.

Structure
REQ-021 Package one_hot_calculator_pkg SHALL hold the state-bit index constants, the 6-bit state vector typedef, and operand/product width constants (4, 8).
REQ-022 Datapath (M, Q, P, CNT, adder, shifters) SHALL be the sub-module one_hot_calculator_datapath, driven by one-hot control strobes load/add/shift from the FSM.

Verification
REQ-023 Clear=0 for 2 cycles with Start=1 -> state IDLE, LED_OUT=8'h00, Start ignored.
REQ-024 Defaults, 1-cycle Start pulse -> LED_OUT=8'h8F exactly 12 edges after Start sampled, 8'h00 before.
REQ-025 A_VAL=15, B_VAL=15 -> LED_OUT=8'hE1 after 13 edges; A_VAL=9, B_VAL=0 -> LED_OUT=8'h00 after 9 edges.
REQ-026 Start pulsed again at edge 5 of a run -> ignored; single result 8'h8F at edge 12; LED_OUT holds 8'h8F thereafter.
REQ-027 Clear=0 at edge 6 of a run -> IDLE, LED_OUT=8'h00; later Start -> 8'h8F after 12 edges.
REQ-028 ONEHOT_RECOVERY_EN defined, state forced to 6'b000011 -> IDLE next edge; a following Start yields 8'h8F.
